// File: rtl/note_seq_datapath.sv
// Note sequencer: records {octave, note} words, plays them back at a fixed
// tempo and asks a VGA drawer to repaint the grid cell of each touched slot.
module note_seq_datapath #(
    parameter int DEPTH = 16,
    parameter int COLS = 4,
    parameter int CELL_W = 36,
    parameter int CELL_H = 12,
    parameter int GAP = 4,
    parameter int TEMPO_DIV = 12500000,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        note_data,
    input  logic [1:0]        octave_data,
    input  logic              rec_strobe,
    input  logic              play_start,
    input  logic              play_stop,
    input  logic              clear,
    input  logic              loop_en,
    output logic [5:0]        note_out,
    output logic              note_valid,
    output logic              playing,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic [7:0]        cell_x,
    output logic [6:0]        cell_y,
    output logic [2:0]        cell_colour,
    output logic              cell_draw
);

    localparam logic [31:0] TEMPO_RELOAD = 32'(TEMPO_DIV - 1);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_CLEAR
    } state_t;

    state_t state;

    logic [5:0]        mem [DEPTH];
    logic [5:0]        rd_data;
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] p1_addr;
    logic [31:0]       tempo;
    logic              v1;
    logic              ending;

    logic              step;
    logic              last_slot;
    logic              do_rec;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [5:0]        mem_wdata;

    function automatic logic [7:0] slot_x(input logic [ADDR_W-1:0] a);
        int v;
        v = GAP + (int'(a) % COLS) * (CELL_W + GAP);
        return v[7:0];
    endfunction

    function automatic logic [6:0] slot_y(input logic [ADDR_W-1:0] a);
        int v;
        v = GAP + (int'(a) / COLS) * (CELL_H + GAP);
        return v[6:0];
    endfunction

    assign step      = (state == S_PLAY) && !ending && (tempo == '0);
    assign last_slot = ({1'b0, rd_addr} == count - 1'b1);
    assign do_rec    = (state == S_IDLE) && rec_strobe && !full
                       && !clear && !play_stop && !play_start;
    assign full      = (count == DEPTH_C);
    assign playing   = (state == S_PLAY);

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_ptr[ADDR_W-1:0];
        mem_wdata = {octave_data, note_data};
        if (reset && state == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = 6'b0;
        end else if (reset && do_rec) begin
            mem_we = 1'b1;
        end
    end

    // Storage has no reset; the read port tracks rd_addr every cycle.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_addr     <= '0;
            clr_addr    <= '0;
            p1_addr     <= '0;
            count       <= '0;
            tempo       <= '0;
            v1          <= 1'b0;
            ending      <= 1'b0;
            note_out    <= '0;
            note_valid  <= 1'b0;
            cell_draw   <= 1'b0;
            cell_colour <= '0;
            cell_x      <= '0;
            cell_y      <= '0;
        end else begin
            note_valid <= 1'b0;
            cell_draw  <= 1'b0;
            v1         <= 1'b0;
            if (tempo != '0) tempo <= tempo - 1'b1;

            unique case (state)
                S_IDLE: begin
                    if (clear) begin
                        state    <= S_CLEAR;
                        clr_addr <= '0;
                    end else if (play_start && !play_stop && count != '0) begin
                        state   <= S_PLAY;
                        rd_addr <= '0;
                        tempo   <= '0;
                        ending  <= 1'b0;
                    end else if (do_rec) begin
                        wr_ptr      <= wr_ptr + 1'b1;
                        count       <= count + 1'b1;
                        cell_draw   <= 1'b1;
                        cell_colour <= 3'b100;
                        cell_x      <= slot_x(wr_ptr[ADDR_W-1:0]);
                        cell_y      <= slot_y(wr_ptr[ADDR_W-1:0]);
                    end
                end
                S_PLAY: begin
                    if (clear) begin
                        state    <= S_CLEAR;
                        clr_addr <= '0;
                    end else if (play_stop) begin
                        state <= S_IDLE;
                    end else begin
                        if (step) begin
                            v1      <= 1'b1;
                            p1_addr <= rd_addr;
                            tempo   <= TEMPO_RELOAD;
                            if (!last_slot) rd_addr <= rd_addr + 1'b1;
                            else if (loop_en) rd_addr <= '0;
                            else ending <= 1'b1;
                        end
                        if (v1) begin
                            note_out    <= rd_data;
                            note_valid  <= 1'b1;
                            cell_draw   <= 1'b1;
                            cell_colour <= 3'b110;
                            cell_x      <= slot_x(p1_addr);
                            cell_y      <= slot_y(p1_addr);
                        end
                        // leave only after the final note has been presented
                        if (note_valid && ending) state <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    cell_draw   <= 1'b1;
                    cell_colour <= 3'b000;
                    cell_x      <= slot_x(clr_addr);
                    cell_y      <= slot_y(clr_addr);
                    if (clr_addr == LAST_SLOT) begin
                        state  <= S_IDLE;
                        wr_ptr <= '0;
                        count  <= '0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_seq_datapath.sv
// Scoreboard bench for note_seq_datapath: expected notes and draws are queued
// as stimulus is driven and popped by a monitor when the DUT pulses.
module tb_note_seq_datapath;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] note_data = '0;
    logic [1:0] octave_data = '0;
    logic       rec_strobe = 1'b0;
    logic       play_start = 1'b0;
    logic       play_stop = 1'b0;
    logic       clear = 1'b0;
    logic       loop_en = 1'b0;
    logic [5:0] note_out;
    logic       note_valid;
    logic       playing;
    logic [4:0] count;
    logic       full;
    logic [7:0] cell_x;
    logic [6:0] cell_y;
    logic [2:0] cell_colour;
    logic       cell_draw;

    always #5 clk = ~clk;

    note_seq_datapath #(
        .DEPTH(16), .COLS(4), .CELL_W(36), .CELL_H(12),
        .GAP(4), .TEMPO_DIV(4)
    ) dut (
        .clk(clk), .reset(reset),
        .note_data(note_data), .octave_data(octave_data),
        .rec_strobe(rec_strobe), .play_start(play_start),
        .play_stop(play_stop), .clear(clear), .loop_en(loop_en),
        .note_out(note_out), .note_valid(note_valid),
        .playing(playing), .count(count), .full(full),
        .cell_x(cell_x), .cell_y(cell_y),
        .cell_colour(cell_colour), .cell_draw(cell_draw)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nv_count = 0;
    int draw_count = 0;
    int last_nv = 0;
    int nv_gap = 0;

    logic [5:0]  note_q[$];
    logic [17:0] draw_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [17:0] exp_draw(int slot, logic [2:0] c);
        int x;
        int y;
        x = 4 + (slot % 4) * 40;
        y = 4 + (slot / 4) * 16;
        return {x[7:0], y[6:0], c};
    endfunction

    always @(negedge clk) begin
        logic [5:0]  en;
        logic [17:0] ed;
        if (note_valid === 1'b1) begin
            nv_count++;
            nv_gap  = cyc - last_nv;
            last_nv = cyc;
            checks++;
            if (note_q.size() == 0) begin
                errors++;
                $display("FAIL note_unexpected: note_out=%h, none required", note_out);
            end else begin
                en = note_q.pop_front();
                if (note_out !== en) begin
                    errors++;
                    $display("FAIL note_value: got %h, required %h", note_out, en);
                end
            end
        end
        if (cell_draw === 1'b1) begin
            draw_count++;
            checks++;
            if (draw_q.size() == 0) begin
                errors++;
                $display("FAIL draw_unexpected: x=%0d y=%0d c=%b, none required",
                         cell_x, cell_y, cell_colour);
            end else begin
                ed = draw_q.pop_front();
                if ({cell_x, cell_y, cell_colour} !== ed) begin
                    errors++;
                    $display("FAIL draw_value: got x=%0d y=%0d c=%b, required x=%0d y=%0d c=%b",
                             cell_x, cell_y, cell_colour, ed[17:10], ed[9:3], ed[2:0]);
                end
            end
        end
    end

    task automatic tick(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rec_note(logic [5:0] w, bit exp_drw, int slot);
        octave_data = w[5:4];
        note_data   = w[3:0];
        rec_strobe  = 1'b1;
        if (exp_drw) draw_q.push_back(exp_draw(slot, 3'b100));
        tick();
        rec_strobe = 1'b0;
    endtask

    task automatic wait_nv(int target, int budget);
        for (int i = 0; i < budget && nv_count < target; i++) tick();
        checks++;
        if (nv_count < target) begin
            errors++;
            $display("FAIL wait_nv_timeout: got %0d pulses, required %0d", nv_count, target);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(2);
        checks++;
        if ({note_out, note_valid, playing, count, full, cell_x, cell_y,
             cell_colour, cell_draw} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: note=%h nv=%b pl=%b cnt=%0d full=%b x=%0d y=%0d c=%b d=%b, required all 0",
                     note_out, note_valid, playing, count, full, cell_x, cell_y, cell_colour, cell_draw);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_record();
        rec_note(6'h21, 1, 0);
        rec_note(6'h05, 1, 1);
        rec_note(6'h3B, 1, 2);
        tick(2);
        checks++;
        if (count !== 5'd3) begin
            errors++;
            $display("FAIL record_count: got %0d, required 3", count);
        end
        checks++;
        if (draw_q.size() != 0) begin
            errors++;
            $display("FAIL record_draws: %0d outstanding, required 0", draw_q.size());
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) rec_note(6'(i * 3 + 1), 1, i);
        tick();
        checks++;
        if (full !== 1'b1 || count !== 5'd16) begin
            errors++;
            $display("FAIL full_flag: full=%b count=%0d, required 1/16", full, count);
        end
        rec_note(6'h2A, 0, 0);
        tick(2);
        checks++;
        if (count !== 5'd16 || draw_q.size() != 0) begin
            errors++;
            $display("FAIL full_ignore: count=%0d outstanding=%0d, required 16/0",
                     count, draw_q.size());
        end
    endtask

    task automatic test_play_once();
        int base;
        int start;
        do_reset();
        rec_note(6'h21, 1, 0);
        rec_note(6'h05, 1, 1);
        loop_en = 1'b0;
        note_q.push_back(6'h21);
        draw_q.push_back(exp_draw(0, 3'b110));
        note_q.push_back(6'h05);
        draw_q.push_back(exp_draw(1, 3'b110));
        base  = nv_count;
        start = cyc;
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        checks++;
        if (playing !== 1'b1) begin
            errors++;
            $display("FAIL play_enter: playing=%b, required 1", playing);
        end
        wait_nv(base + 1, 20);
        checks++;
        if (last_nv != start + 3) begin
            errors++;
            $display("FAIL play_latency: first note at cycle %0d, required %0d", last_nv, start + 3);
        end
        wait_nv(base + 2, 20);
        checks++;
        if (nv_gap != 4) begin
            errors++;
            $display("FAIL play_spacing: gap %0d, required 4", nv_gap);
        end
        for (int i = 0; i < 10 && playing === 1'b1; i++) tick();
        checks++;
        if (playing !== 1'b0) begin
            errors++;
            $display("FAIL play_end: playing=%b, required 0", playing);
        end
        tick(6);
        checks++;
        if (note_out !== 6'h05 || nv_count != base + 2) begin
            errors++;
            $display("FAIL play_hold: note=%h pulses=%0d, required 05/%0d",
                     note_out, nv_count - base, 2);
        end
    endtask

    task automatic test_loop();
        int base;
        logic [5:0] seq [5];
        seq[0] = 6'h21; seq[1] = 6'h05; seq[2] = 6'h21;
        seq[3] = 6'h05; seq[4] = 6'h21;
        for (int i = 0; i < 5; i++) begin
            note_q.push_back(seq[i]);
            draw_q.push_back(exp_draw(i % 2, 3'b110));
        end
        loop_en = 1'b1;
        base = nv_count;
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        rec_note(6'h3F, 0, 0);
        wait_nv(base + 5, 60);
        tick(2);
        play_stop = 1'b1;
        tick();
        play_stop = 1'b0;
        checks++;
        if (playing !== 1'b0) begin
            errors++;
            $display("FAIL loop_stop: playing=%b, required 0", playing);
        end
        tick(12);
        checks++;
        if (nv_count != base + 5 || note_q.size() != 0 || count !== 5'd2) begin
            errors++;
            $display("FAIL loop_after_stop: pulses=%0d left=%0d count=%0d, required 5/0/2",
                     nv_count - base, note_q.size(), count);
        end
        loop_en = 1'b0;
    endtask

    task automatic test_clear_priority();
        int d0;
        for (int i = 0; i < 16; i++) draw_q.push_back(exp_draw(i, 3'b000));
        d0 = draw_count;
        clear = 1'b1;
        play_start = 1'b1;
        rec_strobe = 1'b1;
        tick();
        clear = 1'b0;
        play_start = 1'b0;
        rec_strobe = 1'b0;
        checks++;
        if (playing !== 1'b0) begin
            errors++;
            $display("FAIL clear_priority: playing=%b, required 0", playing);
        end
        tick(20);
        checks++;
        if (draw_count - d0 != 16 || draw_q.size() != 0) begin
            errors++;
            $display("FAIL clear_draws: got %0d, required 16", draw_count - d0);
        end
        checks++;
        if (count !== 5'd0 || full !== 1'b0) begin
            errors++;
            $display("FAIL clear_count: count=%0d full=%b, required 0/0", count, full);
        end
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        checks++;
        if (playing !== 1'b0) begin
            errors++;
            $display("FAIL clear_empty_play: playing=%b, required 0", playing);
        end
        tick(8);
    endtask

    task automatic test_reset_mid_play();
        int base;
        rec_note(6'h21, 1, 0);
        rec_note(6'h05, 1, 1);
        note_q.push_back(6'h21);
        draw_q.push_back(exp_draw(0, 3'b110));
        note_q.push_back(6'h05);
        draw_q.push_back(exp_draw(1, 3'b110));
        loop_en = 1'b1;
        base = nv_count;
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        wait_nv(base + 2, 30);
        tick(2);
        reset = 1'b0;
        tick();
        checks++;
        if ({note_out, note_valid, playing, count, full, cell_x, cell_y,
             cell_colour, cell_draw} !== '0) begin
            errors++;
            $display("FAIL midplay_reset: note=%h nv=%b pl=%b cnt=%0d d=%b, required all 0",
                     note_out, note_valid, playing, count, cell_draw);
        end
        reset = 1'b1;
        tick(15);
        checks++;
        if (count !== 5'd0 || playing !== 1'b0 || nv_count != base + 2) begin
            errors++;
            $display("FAIL midplay_after: count=%0d playing=%b pulses=%0d, required 0/0/2",
                     count, playing, nv_count - base);
        end
        loop_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_record();
        test_full();
        test_play_once();
        test_loop();
        test_clear_priority();
        test_reset_mid_play();
        checks++;
        if (note_q.size() != 0 || draw_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: notes=%0d draws=%0d, required 0/0",
                     note_q.size(), draw_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
